// File: rtl/arb_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        GAP   = 2'b10
    } arb_state_t;

endpackage : arb_pkg

// File: rtl/rr_pick4.sv
// Rotating-priority pick: first set request scanning ptr, ptr+1, ... mod 4.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [2*NUM_REQ-1:0] dbl_s;
    logic [NUM_REQ-1:0]   rot_s;
    logic [IDX_W-1:0]     off_s;

    assign dbl_s = {req, req};
    assign rot_s = dbl_s[ptr +: NUM_REQ];   // rot_s[0] is req[ptr]
    assign any   = |req;
    assign idx   = ptr + off_s;             // 2-bit wrap gives the modulo

    // Priority-encode the rotated vector: lowest set bit is the winner offset.
    always_comb begin
        off_s = 2'd0;
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: off_s = 2'd0;
        endcase
    end

endmodule : rr_pick4

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with grant hold, timeout-forced release
// and a one-cycle break-before-make gap. All outputs are registered.
// Optional macro ARB_LOCK_EN adds a lock input that suppresses forced release.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter  int HOLD_MAX = 16,
    localparam int CNT_W    = $clog2(HOLD_MAX)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
`ifdef ARB_LOCK_EN
    input  logic               lock,
`endif
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid,
    output logic               timeout
);

    arb_state_t        state_r, state_nxt_s;
    logic [CNT_W-1:0]  hold_cnt_r, hold_cnt_nxt_s;
    logic [IDX_W-1:0]  ptr_r, ptr_nxt_s;
    logic [IDX_W-1:0]  idx_nxt_s;
    logic              valid_nxt_s;
    logic              timeout_nxt_s;

    logic [IDX_W-1:0]  pick_idx_s;
    logic              pick_any_s;
    logic              owner_req_s;
    logic              at_max_s;
    logic              lock_s;

`ifdef ARB_LOCK_EN
    assign lock_s = lock;
`else
    assign lock_s = 1'b0;
`endif

    assign owner_req_s = req[grant_idx];
    assign at_max_s    = (hold_cnt_r == CNT_W'(HOLD_MAX - 1));

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr_r),
        .idx (pick_idx_s),
        .any (pick_any_s)
    );

    // State and output registers; reset also aborts a live grant without a gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            hold_cnt_r  <= '0;
            ptr_r       <= 2'b00;
            grant_idx   <= 2'b00;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            hold_cnt_r  <= hold_cnt_nxt_s;
            ptr_r       <= ptr_nxt_s;
            grant_idx   <= idx_nxt_s;
            grant_valid <= valid_nxt_s;
            timeout     <= timeout_nxt_s;
        end
    end

    // Next-state: owner drop or unlocked hold expiry both leave through GAP.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (pick_any_s) state_nxt_s = GRANT;
                else            state_nxt_s = IDLE;
            end
            GRANT: begin
                if (!owner_req_s || (at_max_s && !lock_s)) state_nxt_s = GAP;
                else                                       state_nxt_s = GRANT;
            end
            GAP:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next values of registered outputs, hold counter and rotation pointer.
    always_comb begin
        hold_cnt_nxt_s = hold_cnt_r;
        ptr_nxt_s      = ptr_r;
        idx_nxt_s      = grant_idx;
        valid_nxt_s    = grant_valid;
        timeout_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    idx_nxt_s      = pick_idx_s;
                    valid_nxt_s    = 1'b1;
                    hold_cnt_nxt_s = '0;
                end else begin
                    valid_nxt_s    = 1'b0;
                end
            end
            GRANT: begin
                if (!owner_req_s) begin
                    // A drop wins over a coincident expiry: no timeout pulse.
                    valid_nxt_s = 1'b0;
                    ptr_nxt_s   = grant_idx + 2'd1;
                end else if (at_max_s && !lock_s) begin
                    valid_nxt_s   = 1'b0;
                    ptr_nxt_s     = grant_idx + 2'd1;
                    timeout_nxt_s = 1'b1;
                end else if (!at_max_s) begin
                    hold_cnt_nxt_s = hold_cnt_r + CNT_W'(1);
                end else begin
                    // Locked at the limit: counter saturates, grant persists.
                    hold_cnt_nxt_s = hold_cnt_r;
                end
            end
            GAP: begin
                valid_nxt_s = 1'b0;
            end
            default: begin
                valid_nxt_s = 1'b0;
            end
        endcase
    end

endmodule : rr_arbiter4

// File: tb/tb_rr_arbiter4.sv
// Directed self-checking bench for rr_arbiter4 (HOLD_MAX=4).
// Lock scenario runs only when ARB_LOCK_EN is defined.
module tb_rr_arbiter4;

    logic       clk;
    logic       reset;
    logic [3:0] req;
`ifdef ARB_LOCK_EN
    logic       lock;
`endif
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int checks;
    int failures;

    rr_arbiter4 #(.HOLD_MAX(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
`ifdef ARB_LOCK_EN
        .lock        (lock),
`endif
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] e_idx,
                       input logic e_valid, input logic e_to);
        checks++;
        assert (grant_idx === e_idx) else begin
            failures++;
            $error("FAIL %s grant_idx got=%0d exp=%0d", tag, grant_idx, e_idx);
        end
        checks++;
        assert (grant_valid === e_valid) else begin
            failures++;
            $error("FAIL %s grant_valid got=%0b exp=%0b", tag, grant_valid, e_valid);
        end
        checks++;
        assert (timeout === e_to) else begin
            failures++;
            $error("FAIL %s timeout got=%0b exp=%0b", tag, timeout, e_to);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0] e;
        logic [1:0] seq4 [3];
        checks   = 0;
        failures = 0;
        req      = 4'b0000;
`ifdef ARB_LOCK_EN
        lock     = 1'b0;
`endif

        // Reset state
        do_reset();
        chk("reset", 2'd0, 1'b0, 1'b0);

        // T1: req=0101, owner 0 holds 3 cycles then drops; next winner is 2
        req = 4'b0101;
        step(); chk("t1_grant0_c1", 2'd0, 1'b1, 1'b0);
        step(); chk("t1_grant0_c2", 2'd0, 1'b1, 1'b0);
        step(); chk("t1_grant0_c3", 2'd0, 1'b1, 1'b0);
        req = 4'b0100;
        step(); chk("t1_gap", 2'd0, 1'b0, 1'b0);
        step(); chk("t1_idle", 2'd0, 1'b0, 1'b0);
        step(); chk("t1_grant2", 2'd2, 1'b1, 1'b0);
        req = 4'b0000;
        step(); chk("t1_gap2", 2'd2, 1'b0, 1'b0);

        // T2: all request; each owner drops after 2 grant cycles -> 0,1,2,3,0
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            e = 2'(k);
            step(); chk("t2_grant_c1", e, 1'b1, 1'b0);
            step(); chk("t2_grant_c2", e, 1'b1, 1'b0);
            req = 4'b1111 & ~(4'b0001 << e);
            step(); chk("t2_gap", e, 1'b0, 1'b0);
            req = 4'b1111;
            step(); chk("t2_idle", e, 1'b0, 1'b0);
        end

        // T3: sole requester 1 held -> 4 grant cycles, timeout, gap, re-grant
        do_reset();
        req = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            step(); chk("t3_hold", 2'd1, 1'b1, 1'b0);
        end
        step(); chk("t3_timeout", 2'd1, 1'b0, 1'b1);
        step(); chk("t3_idle", 2'd1, 1'b0, 1'b0);
        step(); chk("t3_regrant", 2'd1, 1'b1, 1'b0);
        req = 4'b0000;
        step(); chk("t3_drop", 2'd1, 1'b0, 1'b0);

        // T4: req=0011 held -> 0,1,0 each ended by a timeout pulse
        do_reset();
        req = 4'b0011;
        seq4[0] = 2'd0; seq4[1] = 2'd1; seq4[2] = 2'd0;
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 4; i++) begin
                step(); chk("t4_hold", seq4[g], 1'b1, 1'b0);
            end
            step(); chk("t4_timeout", seq4[g], 1'b0, 1'b1);
            step(); chk("t4_idle", seq4[g], 1'b0, 1'b0);
        end

        // T5: reset in 2nd grant cycle of owner 3 aborts without gap
        do_reset();
        req = 4'b1000;
        step(); chk("t5_grant_c1", 2'd3, 1'b1, 1'b0);
        step(); chk("t5_grant_c2", 2'd3, 1'b1, 1'b0);
        reset = 1'b1;
        step(); chk("t5_reset", 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        step(); chk("t5_regrant", 2'd3, 1'b1, 1'b0);

        // T6: owner drops in the same cycle the hold limit is reached
        do_reset();
        req = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            step(); chk("t6_hold", 2'd2, 1'b1, 1'b0);
        end
        req = 4'b0000;
        step(); chk("t6_drop_no_to", 2'd2, 1'b0, 1'b0);
        step(); chk("t6_idle", 2'd2, 1'b0, 1'b0);

`ifdef ARB_LOCK_EN
        // T7: lock holds owner 2 for 10 cycles, release fires after unlock
        do_reset();
        lock = 1'b1;
        req  = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            step(); chk("t7_locked", 2'd2, 1'b1, 1'b0);
        end
        lock = 1'b0;
        step(); chk("t7_unlock_to", 2'd2, 1'b0, 1'b1);
        step(); chk("t7_idle", 2'd2, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rr_arbiter4
